// File: rtl/block_ram_arbiter_if.sv
// Memory bus shared by requesters and the block RAM.
// MEM is the memory-side view (takes a request, returns data/ready);
// CPU is the requester-side view (issues a request, receives data/ready).
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/block_ram_arbiter.sv
// Two-requester arbiter in front of a single block RAM/ROM port.
//
// Handshake: a requester holds re or any we bit high together with stable
// addr/wdata until it sees ready=1 on its own port; that cycle completes
// the access. The memory completes an access on the cycle it asserts
// ready, and read data appears on rdata one cycle later. The arbiter adds
// no latency: the granted request passes straight through to the memory,
// and ready is routed back only to the granted port.
//
// A grant made in IDLE that does not complete immediately is locked in
// (BUSY_A/BUSY_B) so the other port cannot steal the memory mid-access.
module block_ram_arbiter #(
  parameter int fixed_prio = 0
) (
  input  logic       clk,
  input  logic       rst,
  boa_mem_bus.MEM    a,
  boa_mem_bus.MEM    b,
  boa_mem_bus.CPU    mem,
  output logic [1:0] dbg_state,
  output logic       dbg_lg,
  output logic       dbg_rs
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  // Port encoding for the last-grant and read-select registers.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t state, state_nx;
  logic   lg, lg_nx;
  logic   rs, rs_nx;
  logic   req_a, req_b;
  logic   gnt_a, gnt_b;

  assign req_a = a.re | (|a.we);
  assign req_b = b.re | (|b.we);

  // Next-state, grant and bookkeeping; reset suppresses every grant.
  always_comb begin
    state_nx = state;
    lg_nx    = lg;
    rs_nx    = rs;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_a && req_b) begin
            if ((fixed_prio != 0) || (lg == SEL_B)) gnt_a = 1'b1;
            else                                    gnt_b = 1'b1;
          end else begin
            gnt_a = req_a;
            gnt_b = req_b;
          end
          if (gnt_a || gnt_b) begin
            if (mem.ready) begin
              lg_nx = gnt_b;
              rs_nx = gnt_b;
            end else begin
              state_nx = gnt_a ? BUSY_A : BUSY_B;
            end
          end
        end
        BUSY_A: begin
          if (!req_a) begin
            // Owner abandoned its access: release without crediting it.
            state_nx = IDLE;
          end else begin
            gnt_a = 1'b1;
            if (mem.ready) begin
              state_nx = IDLE;
              lg_nx    = SEL_A;
              rs_nx    = SEL_A;
            end
          end
        end
        BUSY_B: begin
          if (!req_b) begin
            state_nx = IDLE;
          end else begin
            gnt_b = 1'b1;
            if (mem.ready) begin
              state_nx = IDLE;
              lg_nx    = SEL_B;
              rs_nx    = SEL_B;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, last-grant and read-select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lg    <= SEL_B;
      rs    <= SEL_A;
    end else begin
      state <= state_nx;
      lg    <= lg_nx;
      rs    <= rs_nx;
    end
  end

  // Request path to memory: granted port or all zeros.
  assign mem.re    = gnt_a ? a.re    : (gnt_b ? b.re    : 1'b0);
  assign mem.we    = gnt_a ? a.we    : (gnt_b ? b.we    : 4'b0000);
  assign mem.addr  = gnt_a ? a.addr  : (gnt_b ? b.addr  : 32'h0);
  assign mem.wdata = gnt_a ? a.wdata : (gnt_b ? b.wdata : 32'h0);

  // Response path: ready only to the granted port, data to both.
  assign a.ready = gnt_a & mem.ready;
  assign b.ready = gnt_b & mem.ready;
  assign a.rdata = mem.rdata;
  assign b.rdata = mem.rdata;

  assign dbg_state = state;
  assign dbg_lg    = lg;
  assign dbg_rs    = rs;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Bench for block_ram_arbiter: a round-robin instance driven by a cycle
// table, plus a fixed-priority instance and a small RAM model for the
// read-data and priority sequences.
module tb_block_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_re, b_re, mem_ready;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

  int n_cmp = 0;
  int n_err = 0;

  // Two DUTs see identical requester stimulus on separate buses.
  boa_mem_bus ia0 ();
  boa_mem_bus ib0 ();
  boa_mem_bus im0 ();
  boa_mem_bus ia1 ();
  boa_mem_bus ib1 ();
  boa_mem_bus im1 ();

  assign ia0.re = a_re;  assign ia0.we = a_we;  assign ia0.addr = a_addr;  assign ia0.wdata = a_wdata;
  assign ib0.re = b_re;  assign ib0.we = b_we;  assign ib0.addr = b_addr;  assign ib0.wdata = b_wdata;
  assign ia1.re = a_re;  assign ia1.we = a_we;  assign ia1.addr = a_addr;  assign ia1.wdata = a_wdata;
  assign ib1.re = b_re;  assign ib1.we = b_we;  assign ib1.addr = b_addr;  assign ib1.wdata = b_wdata;
  assign im0.ready = mem_ready;
  assign im1.ready = mem_ready;
  assign im1.rdata = 32'h0;

  logic [1:0] st0, st1;
  logic       lg0, lg1, rs0, rs1;

  block_ram_arbiter #(.fixed_prio(0)) dut0 (
    .clk(clk), .rst(rst), .a(ia0), .b(ib0), .mem(im0),
    .dbg_state(st0), .dbg_lg(lg0), .dbg_rs(rs0)
  );

  block_ram_arbiter #(.fixed_prio(1)) dut1 (
    .clk(clk), .rst(rst), .a(ia1), .b(ib1), .mem(im1),
    .dbg_state(st1), .dbg_lg(lg1), .dbg_rs(rs1)
  );

  // One-cycle-latency RAM behind dut0.
  logic [31:0] ram [16];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h1000_0000 + i;
    ram[4] = 32'hDEAD_BEEF;
    im0.rdata = 32'h0;
  end
  always @(posedge clk) if (im0.re && im0.ready) im0.rdata <= ram[im0.addr[5:2]];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The two ready outputs of each DUT must never coincide.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("mutex_ready0", {31'h0, ia0.ready & ib0.ready}, 32'h0);
      check("mutex_ready1", {31'h0, ia1.ready & ib1.ready}, 32'h0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        a_re;  logic [3:0] a_we; logic [31:0] a_addr; logic [31:0] a_wdata;
    logic        b_re;  logic [3:0] b_we; logic [31:0] b_addr; logic [31:0] b_wdata;
    logic        ready;
    logic        e_ar;  logic e_br; logic e_re; logic [3:0] e_we;
    logic [31:0] e_addr; logic [31:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic are, input logic [3:0] awe, input logic [31:0] aad, input logic [31:0] awd,
    input logic bre, input logic [3:0] bwe, input logic [31:0] bad, input logic [31:0] bwd, input logic rdy,
    input logic ear, input logic ebr, input logic ere, input logic [3:0] ewe,
    input logic [31:0] ead, input logic [31:0] ewd);
    vec_t v;
    v.rst = r;
    v.a_re = are; v.a_we = awe; v.a_addr = aad; v.a_wdata = awd;
    v.b_re = bre; v.b_we = bwe; v.b_addr = bad; v.b_wdata = bwd;
    v.ready = rdy;
    v.e_ar = ear; v.e_br = ebr; v.e_re = ere; v.e_we = ewe; v.e_addr = ead; v.e_wdata = ewd;
    return v;
  endfunction

  localparam logic [31:0] AA = 32'h0000_0100, AW = 32'hAAAA_0000;
  localparam logic [31:0] BA = 32'h0000_0200, BW = 32'hBBBB_0000;
  localparam logic [31:0] WA = 32'h0000_0204, WD = 32'h1234_5678;
  localparam logic [31:0] XA = 32'h0000_0108, XD = 32'hCAFE_F00D;

  vec_t vecs [$];

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    rst = v.rst;
    a_re = v.a_re; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_re = v.b_re; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    mem_ready = v.ready;
  endtask

  task automatic idle_inputs();
    a_re = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_re = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    mem_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset with requests pending: everything quiet.
    vecs.push_back(mk(1, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  0,0,0,4'h0,32'h0,32'h0));
    // Five idle cycles.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,4'h0,AA,AW, 0,4'h0,BA,BW, 1,  0,0,0,4'h0,32'h0,32'h0));
    // Continuous tie, round-robin: A,B,A,B.
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk(0, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  1,0,1,4'h0,AA,AW));
      vecs.push_back(mk(0, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  0,1,1,4'h0,BA,BW));
    end
    // B write held by two wait cycles; A joins on the second cycle.
    vecs.push_back(mk(0, 0,4'h0,AA,AW, 0,4'h3,WA,WD, 0,  0,0,0,4'h3,WA,WD));
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 0,4'h3,WA,WD, 0,  0,0,0,4'h3,WA,WD));
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 0,4'h3,WA,WD, 1,  0,1,0,4'h3,WA,WD));
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 0,4'h0,BA,BW, 1,  1,0,1,4'h0,AA,AW));
    // A stalls, reset hits mid-access, then first tie goes to A.
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 0,4'h0,BA,BW, 0,  0,0,1,4'h0,AA,AW));
    vecs.push_back(mk(1, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  0,0,0,4'h0,32'h0,32'h0));
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  1,0,1,4'h0,AA,AW));
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  0,1,1,4'h0,BA,BW));
    // A write stalls, A drops its request: release without lg update.
    vecs.push_back(mk(0, 0,4'hF,XA,XD, 0,4'h0,BA,BW, 0,  0,0,0,4'hF,XA,XD));
    vecs.push_back(mk(0, 0,4'h0,XA,XD, 1,4'h0,BA,BW, 1,  0,0,0,4'h0,32'h0,32'h0));
    vecs.push_back(mk(0, 1,4'h0,AA,AW, 1,4'h0,BA,BW, 1,  1,0,1,4'h0,AA,AW));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_a_ready", i), {31'h0, ia0.ready}, {31'h0, vecs[i].e_ar});
      check($sformatf("v%0d_b_ready", i), {31'h0, ib0.ready}, {31'h0, vecs[i].e_br});
      check($sformatf("v%0d_mem_re", i),  {31'h0, im0.re},    {31'h0, vecs[i].e_re});
      check($sformatf("v%0d_mem_we", i),  {28'h0, im0.we},    {28'h0, vecs[i].e_we});
      check($sformatf("v%0d_mem_addr", i),  im0.addr,  vecs[i].e_addr);
      check($sformatf("v%0d_mem_wdata", i), im0.wdata, vecs[i].e_wdata);
    end

    // Read of word 4 with immediate ready, then B reads word 5.
    do_reset();
    @(posedge clk); #1;
    idle_inputs(); a_re = 1; a_addr = 32'h10; mem_ready = 1;
    @(negedge clk);
    check("rd_a_ready",  {31'h0, ia0.ready}, 32'h1);
    check("rd_b_ready",  {31'h0, ib0.ready}, 32'h0);
    check("rd_mem_addr", im0.addr, 32'h10);
    @(posedge clk); #1;
    a_re = 0; b_re = 1; b_addr = 32'h14;
    @(negedge clk);
    check("rd_a_rdata",  ia0.rdata, 32'hDEAD_BEEF);
    check("rd_b_bcast",  ib0.rdata, 32'hDEAD_BEEF);
    check("rd_b_ready",  {31'h0, ib0.ready}, 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rd_b_rdata",  ib0.rdata, 32'h1000_0005);

    // Fixed priority: A wins every tie.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      a_re = 1; a_addr = AA; a_wdata = AW;
      b_re = 1; b_addr = BA; b_wdata = BW;
      mem_ready = 1;
      @(negedge clk);
      check($sformatf("fp%0d_a_ready", i), {31'h0, ia1.ready}, 32'h1);
      check($sformatf("fp%0d_b_ready", i), {31'h0, ib1.ready}, 32'h0);
      check($sformatf("fp%0d_mem_addr", i), im1.addr, AA);
    end

    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
